// File: rtl/moving_average.sv
// Boxcar moving-average filter over the last 2**LOG2_N accepted samples.
// Circular buffer plus running sum; mean is registered one cycle after accept.
module moving_average #(
    parameter int DW     = 8,
    parameter int LOG2_N = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic signed [DW-1:0] i_data,
    input  logic                 i_valid,
    output logic signed [DW-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_primed
);

    localparam int N  = 1 << LOG2_N;
    localparam int AW = DW + LOG2_N;

    localparam logic [LOG2_N-1:0] PTR_ONE  = 1;
    localparam logic [LOG2_N:0]   FILL_ONE = 1;
    localparam logic [LOG2_N:0]   FILL_N   = N;
    localparam logic [LOG2_N:0]   FILL_LST = N - 1;

    logic signed [DW-1:0] buf_q [N];
    logic [LOG2_N-1:0]    ptr_q, ptr_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [LOG2_N:0]      fill_q, fill_d;
    logic signed [DW-1:0] data_q, data_d;
    logic                 valid_q;
    logic                 primed_q, primed_d;

    logic signed [AW-1:0] din_ext;
    logic signed [AW-1:0] old_ext;
    logic signed [DW-1:0] old_smp;

    assign old_smp = buf_q[ptr_q];
    assign din_ext = {{LOG2_N{i_data[DW-1]}}, i_data};
    assign old_ext = {{LOG2_N{old_smp[DW-1]}}, old_smp};

    always_comb begin
        acc_d    = acc_q + din_ext - old_ext;
        ptr_d    = ptr_q + PTR_ONE;
        fill_d   = (fill_q == FILL_N) ? fill_q : fill_q + FILL_ONE;
        // Dropping the low LOG2_N bits is an arithmetic shift (floor);
        // the mean of DW-bit samples always fits back in DW bits.
        data_d   = acc_d[AW-1:LOG2_N];
        primed_d = primed_q | (fill_q >= FILL_LST);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
            ptr_q    <= '0;
            acc_q    <= '0;
            fill_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            valid_q <= i_valid;
            if (i_valid) begin
                buf_q[ptr_q] <= i_data;
                ptr_q        <= ptr_d;
                acc_q        <= acc_d;
                fill_q       <= fill_d;
                data_q       <= data_d;
                primed_q     <= primed_d;
            end
        end
    end

    assign o_data   = data_q;
    assign o_valid  = valid_q;
    assign o_primed = primed_q;

endmodule

// File: tb/tb_moving_average.sv
// Directed bench for moving_average (DW=8, N=4) with hand-computed means.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_moving_average;

    logic              clk;
    logic              rst_n;
    logic signed [7:0] din;
    logic              vin;
    logic signed [7:0] dout;
    logic              vout;
    logic              primed;

    int n_cmp = 0;
    int n_bad = 0;

    moving_average #(.DW(8), .LOG2_N(2)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_data    (din),
        .i_valid   (vin),
        .o_data    (dout),
        .o_valid   (vout),
        .o_primed  (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input int d, input int v,
                             input int p);
        check({tag, ".data"}, int'(dout), d);
        check({tag, ".valid"}, int'(vout), v);
        check({tag, ".primed"}, int'(primed), p);
    endtask

    // Drive one cycle, then check the registered result after the edge.
    task automatic step(input string tag, input int d, input bit v,
                        input int ed, input int ev, input int ep);
        din = 8'(d);
        vin = v;
        @(posedge clk);
        #1;
        check_out(tag, ed, ev, ep);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vin   = 1'b0;
        din   = '0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    int step_exp [6] = '{10, 20, 30, 40, 40, 40};
    int neg_exp  [4] = '{-2, -3, -4, -5};
    int ext_exp  [8] = '{31, 63, 95, 127, 63, -1, -65, -128};

    initial begin
        rst_n = 1'b0;
        din   = 8'h55;
        vin   = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_out($sformatf("rst%0d", i), 0, 0, 0);
        end

        do_reset();
        for (int i = 0; i < 6; i++) begin
            step($sformatf("step%0d", i), 40, 1'b1, step_exp[i], 1,
                 (i >= 3) ? 1 : 0);
        end

        do_reset();
        for (int i = 0; i < 4; i++) begin
            step($sformatf("neg%0d", i), -5, 1'b1, neg_exp[i], 1,
                 (i >= 3) ? 1 : 0);
        end

        do_reset();
        for (int i = 0; i < 8; i++) begin
            step($sformatf("ext%0d", i), (i < 4) ? 127 : -128, 1'b1,
                 ext_exp[i], 1, (i >= 3) ? 1 : 0);
        end

        do_reset();
        step("gap0", 40, 1'b1, 10, 1, 0);
        step("gap1", 40, 1'b1, 20, 1, 0);
        step("gap2", 99, 1'b0, 20, 0, 0);
        step("gap3", -7, 1'b0, 20, 0, 0);
        step("gap4", 0,  1'b0, 20, 0, 0);
        step("gap5", 40, 1'b1, 30, 1, 0);
        step("gap6", 40, 1'b1, 40, 1, 1);

        do_reset();
        step("mid0", 40, 1'b1, 10, 1, 0);
        step("mid1", 40, 1'b1, 20, 1, 0);
        step("mid2", 40, 1'b1, 30, 1, 0);
        step("mid3", 40, 1'b1, 40, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async", 0, 0, 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step($sformatf("post%0d", i), 40, 1'b1, step_exp[i], 1,
                 (i >= 3) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
